// File: rtl/vu_dmem_vec_responder.sv
`default_nettype none
// ============================================================================
//  Module      : vu_dmem_vec_responder
//  Description : Memory-side responder for the vector dmem port. Accepts
//                128-bit line loads/stores on a val/rdy request port, keeps
//                an internal line store, and returns tagged load data a
//                fixed LAT cycles after acceptance. External stall input
//                for backpressure injection; load/store counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module vu_dmem_vec_responder #(
    parameter int DEPTH = 256,
    parameter int LAT   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [27:0]  dmem_req_vec_addr,
    input  logic [3:0]   dmem_req_vec_op,
    input  logic [127:0] dmem_req_vec_data,
    input  logic [15:0]  dmem_req_vec_wmask,
    input  logic [11:0]  dmem_req_vec_tag,
    input  logic         dmem_req_vec_val,
    output logic         dmem_req_vec_rdy,
    output logic         dmem_resp_vec_val,
    output logic [11:0]  dmem_resp_vec_tag,
    output logic [127:0] dmem_resp_vec_data,
    input  logic         stall,
    output logic [31:0]  load_count,
    output logic [31:0]  store_count
);

    localparam int         IDX_W      = $clog2(DEPTH);
    localparam logic [3:0] c_OP_LOAD  = 4'b0000;
    localparam logic [3:0] c_OP_STORE = 4'b0001;

    logic [127:0]     r_mem [DEPTH];
    logic [IDX_W-1:0] w_idx;
    logic             w_fire;
    logic             w_load_fire;
    logic             w_store_fire;
    logic             w_unused_addr;

    // One entry per latency stage; the last stage drives the response port.
    logic             r_pv    [LAT];
    logic [11:0]      r_ptag  [LAT];
    logic [127:0]     r_pdata [LAT];

    logic [31:0]      r_load_count;
    logic [31:0]      r_store_count;

    // Upper address bits alias onto the same line and are deliberately dropped.
    assign w_idx         = dmem_req_vec_addr[IDX_W-1:0];
    assign w_unused_addr = ^dmem_req_vec_addr[27:IDX_W];

    assign dmem_req_vec_rdy = ~stall & ~reset;
    assign w_fire           = dmem_req_vec_val & dmem_req_vec_rdy;
    assign w_load_fire      = w_fire & (dmem_req_vec_op == c_OP_LOAD);
    assign w_store_fire     = w_fire & (dmem_req_vec_op == c_OP_STORE);

    // Byte-masked store into the line store; contents are never reset.
    always_ff @(posedge clk) begin
        if (w_store_fire) begin
            for (int i = 0; i < 16; i++) begin
                if (dmem_req_vec_wmask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= dmem_req_vec_data[8*i +: 8];
                end
            end
        end
    end

    // Stage 0 valid: set on load fire, cleared by reset (drops in-flight loads).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pv[0] <= 1'b0;
        end else begin
            r_pv[0] <= w_load_fire;
        end
    end

    // Stage 0 payload: captures tag and the line as it stands in the fire cycle.
    always_ff @(posedge clk) begin
        if (w_load_fire) begin
            r_ptag[0]  <= dmem_req_vec_tag;
            r_pdata[0] <= r_mem[w_idx];
        end
    end

    generate
        for (genvar k = 1; k < LAT; k++) begin : g_stage
            // Later stages shift every cycle; stall never freezes the pipeline.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_pv[k] <= 1'b0;
                end else begin
                    r_pv[k] <= r_pv[k-1];
                end
            end

            // Payload shifts alongside its valid bit; no reset needed.
            always_ff @(posedge clk) begin
                r_ptag[k]  <= r_ptag[k-1];
                r_pdata[k] <= r_pdata[k-1];
            end
        end
    endgenerate

    // Accepted-request counters; no-op codes leave both untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_load_count  <= 32'd0;
            r_store_count <= 32'd0;
        end else begin
            if (w_load_fire) begin
                r_load_count <= r_load_count + 32'd1;
            end
            if (w_store_fire) begin
                r_store_count <= r_store_count + 32'd1;
            end
        end
    end

    assign dmem_resp_vec_val  = r_pv[LAT-1];
    assign dmem_resp_vec_tag  = r_ptag[LAT-1];
    assign dmem_resp_vec_data = r_pdata[LAT-1];
    assign load_count         = r_load_count;
    assign store_count        = r_store_count;

endmodule
`default_nettype wire

// File: tb/tb_vu_dmem_vec_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vu_dmem_vec_responder
//  Description : Scoreboard bench for vu_dmem_vec_responder. Stimulus pushes
//                expected load responses (with due cycle) into a queue; a
//                negedge monitor pops and compares whenever a response shows.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vu_dmem_vec_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic         clk;
    logic         reset;
    logic [27:0]  addr;
    logic [3:0]   op;
    logic [127:0] wdata;
    logic [15:0]  wmask;
    logic [11:0]  tag;
    logic         val;
    logic         rdy;
    logic         resp_val;
    logic [11:0]  resp_tag;
    logic [127:0] resp_data;
    logic         stall;
    logic [31:0]  load_count;
    logic [31:0]  store_count;

    vu_dmem_vec_responder #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk                (clk),
        .reset              (reset),
        .dmem_req_vec_addr  (addr),
        .dmem_req_vec_op    (op),
        .dmem_req_vec_data  (wdata),
        .dmem_req_vec_wmask (wmask),
        .dmem_req_vec_tag   (tag),
        .dmem_req_vec_val   (val),
        .dmem_req_vec_rdy   (rdy),
        .dmem_resp_vec_val  (resp_val),
        .dmem_resp_vec_tag  (resp_tag),
        .dmem_resp_vec_data (resp_data),
        .stall              (stall),
        .load_count         (load_count),
        .store_count        (store_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0]  tag;
        logic [127:0] data;
        int           due;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] mdl_mem [DEPTH];
    int           exp_lc = 0;
    int           exp_sc = 0;
    int           errors = 0;
    int           checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: applies the request rules to plain arrays/queues.
    task automatic step(input logic rst, input logic v, input logic st, input logic [3:0] o,
                        input logic [27:0] a, input logic [127:0] d, input logic [15:0] m,
                        input logic [11:0] t);
        int idx;
        @(posedge clk);
        #1;
        reset = rst; val = v; stall = st; op = o; addr = a; wdata = d; wmask = m; tag = t;
        idx = int'(a) % DEPTH;
        if (rst) begin
            while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
            exp_lc = 0;
            exp_sc = 0;
        end else if (v && !st) begin
            if (o == 4'b0000) begin
                sb.push_back('{tag: t, data: mdl_mem[idx], due: cyc + LAT});
                exp_lc++;
            end else if (o == 4'b0001) begin
                for (int i = 0; i < 16; i++)
                    if (m[i]) mdl_mem[idx][8*i +: 8] = d[8*i +: 8];
                exp_sc++;
            end
        end
        #1;
        chk("rdy", {127'd0, rdy}, {127'd0, (!st && !rst)});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 28'h0, 128'h0, 16'h0, 12'h0);
    endtask

    task automatic req(input logic [3:0] o, input logic [27:0] a, input logic [127:0] d,
                       input logic [15:0] m, input logic [11:0] t);
        step(1'b0, 1'b1, 1'b0, o, a, d, m, t);
    endtask

    task automatic check_counts(input string name);
        @(negedge clk);
        chk({name, "_load_count"}, {96'd0, load_count}, {96'd0, 32'(exp_lc)});
        chk({name, "_store_count"}, {96'd0, store_count}, {96'd0, 32'(exp_sc)});
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Monitor: every response must match the oldest outstanding load, on its due cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL resp_missing: tag %h due cycle %0d never seen (now %0d)",
                     sb[0].tag, sb[0].due, cyc);
            void'(sb.pop_front());
        end
        if (resp_val === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL resp_unexpected: got tag %h expected no response (cycle %0d)",
                         resp_tag, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_cycle", 128'(cyc), 128'(e.due));
                chk("resp_tag", {116'd0, resp_tag}, {116'd0, e.tag});
                chk("resp_data", resp_data, e.data);
            end
        end else if (resp_val !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL resp_val_x: got %b expected 0 or 1 (cycle %0d)", resp_val, cyc);
        end
    end

    initial begin
        reset = 1'b1; val = 1'b0; stall = 1'b0; op = 4'h0;
        addr = 28'h0; wdata = 128'h0; wmask = 16'h0; tag = 12'h0;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 4'h0, 28'h0, 128'h0, 16'h0, 12'h0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 28'h0, 128'h0, 16'h0, 12'h0);
        idle(1);
        check_counts("reset");
        chk("reset_resp_val", {127'd0, resp_val}, 128'd0);

        // Full store then load
        req(4'b0001, 28'h5, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'hFFFF, 12'h001);
        req(4'b0000, 28'h5, 128'h0, 16'h0, 12'hABC);
        idle(LAT + 1);
        check_counts("basic");

        // Partial store then load
        req(4'b0001, 28'h5, {128{1'b1}}, 16'h000F, 12'h002);
        req(4'b0000, 28'h5, 128'h0, 16'h0, 12'h003);
        idle(LAT + 1);

        // Prewrite lines 0..15 and 0x10..0x17 with random data
        for (int i = 0; i < 24; i++) req(4'b0001, 28'(i), rnd128(), 16'hFFFF, 12'(i));
        // 8 back-to-back loads, tags 0..7
        for (int i = 0; i < 8; i++) req(4'b0000, 28'(16 + i), 128'h0, 16'h0, 12'(i));
        idle(LAT + 1);
        check_counts("b2b");

        // Stall for 3 cycles while a response is in flight
        req(4'b0000, 28'h3, 128'h0, 16'h0, 12'h100);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 4'b0000, 28'h4, 128'h0, 16'h0, 12'h101);
        req(4'b0000, 28'h4, 128'h0, 16'h0, 12'h101);
        idle(LAT + 1);
        check_counts("stall");

        // Address alias and no-op code
        req(4'b0001, 28'h105, rnd128(), 16'hFFFF, 12'h200);
        req(4'b0000, 28'h005, 128'h0, 16'h0, 12'h201);
        req(4'b0111, 28'h005, rnd128(), 16'hFFFF, 12'h202);
        idle(LAT + 1);
        check_counts("alias_noop");

        // Consecutive store/load to the same line
        req(4'b0001, 28'h7, rnd128(), 16'hA5A5, 12'h300);
        req(4'b0000, 28'h7, 128'h0, 16'h0, 12'h301);
        idle(LAT + 1);

        // Reset one cycle after a load fire drops it
        req(4'b0000, 28'h2, 128'h0, 16'h0, 12'h400);
        step(1'b1, 1'b0, 1'b0, 4'h0, 28'h0, 128'h0, 16'h0, 12'h0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 28'h0, 128'h0, 16'h0, 12'h0);
        idle(LAT + 2);
        check_counts("post_reset");
        req(4'b0000, 28'h2, 128'h0, 16'h0, 12'h401);
        idle(LAT + 1);

        // Randomized traffic over initialised lines 0..15 with aliasing upper bits
        for (int n = 0; n < 400; n++) begin
            logic        v;
            logic        st;
            logic [3:0]  o;
            int          r;
            logic [27:0] a;
            v  = ($urandom_range(0, 9) < 8);
            st = ($urandom_range(0, 9) < 2);
            r  = $urandom_range(0, 19);
            o  = (r < 9) ? 4'b0000 : (r < 18) ? 4'b0001 : 4'($urandom_range(2, 15));
            a  = 28'(($urandom() << 8) | $urandom_range(0, 15));
            step(1'b0, v, st, o, a, rnd128(), 16'($urandom()), 12'($urandom()));
        end
        idle(LAT + 2);
        check_counts("random");

        chk("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vu_dmem_vec_responder.md
Name: vu_dmem_vec_responder

Overview:
- Memory-side responder for the vector dmem port: accepts 128-bit line requests (addr/op/data/wmask/tag, val/rdy), performs them on an internal line store, returns tagged load data after a fixed latency on the resp port (val only, no rdy).
- Serves as the far end of the VMU vector memory interface: cache stand-in for VMU bring-up, and the reference responder the VMU bench checks against.
- Includes an external stall input for backpressure injection, plus load/store counters.

Parameters:
- DEPTH, 256, number of 128-bit lines in the store; power of two, at least 2; index = addr[log2(DEPTH)-1:0], upper address bits ignored.
- LAT, 2, cycles from request acceptance to load response valid; at least 1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- dmem_req_vec_addr  in  28  line address (byte address >> 4).
- dmem_req_vec_op  in  4  4'b0000 = load, 4'b0001 = store, all other codes = no-op.
- dmem_req_vec_data  in  128  store data.
- dmem_req_vec_wmask  in  16  store byte enables; bit i covers data[8i+7:8i].
- dmem_req_vec_tag  in  12  request tag, echoed on the load response.
- dmem_req_vec_val  in  1  request valid.
- dmem_req_vec_rdy  out  1  responder can accept a request.
- dmem_resp_vec_val  out  1  load response valid (single-cycle pulse).
- dmem_resp_vec_tag  out  12  tag of the responding load.
- dmem_resp_vec_data  out  128  load data.
- stall  in  1  when 1, forces rdy low this cycle.
- load_count  out  32  number of loads accepted since reset.
- store_count  out  32  number of stores accepted since reset.

Behaviour:
- Handshake:
  - rdy = ~stall & ~reset, purely combinational; rdy has no dependence on val.
  - A request is accepted ("fire") on a cycle where val & rdy; at most one request per cycle.
- Store fire:
  - Line[idx] byte i is written with data byte i for every set wmask[i], at the clock edge; unmasked bytes are unchanged.
  - No response is produced.
  - store_count increments by 1, wrapping at 2^32.
- Load fire:
  - Line[idx] is read as of the fire cycle; a store accepted on an earlier cycle is always visible.
  - The {tag, data} pair enters a LAT-deep shift pipeline.
  - dmem_resp_vec_val is asserted exactly LAT cycles after the fire edge, for one cycle, carrying that tag and data.
  - load_count increments by 1, wrapping at 2^32.
- No-op fire: the request is consumed; there is no memory effect, no response and no counter change.
- Pipeline:
  - Each stage holds a valid bit, a tag and data.
  - It advances every cycle unconditionally; stall does not freeze it, and the response side has no backpressure.
  - Back-to-back loads give back-to-back responses, in order, with throughput 1 per cycle.
- Latency is fixed and independent of stall, address and op history.
- Response outputs:
  - When resp_val = 0, tag and data hold the last stage contents; the consumer must not sample them.
  - The bench checks tag/data only when val = 1.
- Reset:
  - All pipeline valid bits are cleared; load_count = store_count = 0; resp_val = 0; rdy = 0 during reset.
  - Loads in flight when reset is asserted are dropped and never responded.
  - Line contents are not reset; a read of a never-written line returns X/undefined.
- Simultaneous events:
  - A stall arriving in the same cycle as a response emission does not affect the response.
  - A store and a load to the same line on consecutive cycles: the load returns the post-store data.
- Address wrap: addr values differing only above bit log2(DEPTH)-1 alias to the same line.

Test Plan:
- Reset, then store addr=0x5, data=0x00112233_44556677_8899AABB_CCDDEEFF, wmask=0xFFFF, tag=0x001; then load addr=0x5, tag=0xABC -> exactly 2 cycles after the load fire, resp_val=1, tag=0xABC, data equal to the stored value; store_count=1, load_count=1.
- Partial store to line 0x5 with wmask=0x000F and data all 0xFF, then load -> data = 0x00112233_44556677_8899AABB_FFFFFFFF.
- 8 back-to-back loads with tags 0..7 to distinct prewritten lines -> 8 consecutive resp_val cycles starting at fire+2, tags 0..7 in order, correct data each.
- Stall held high for 3 cycles with val=1 -> rdy=0 and no fire; a response already in flight still emerges on time; the load fires on the first cycle after stall drops, and load_count increments by 1 only.
- Store to addr 0x105 with DEPTH=256, then load addr 0x005 -> returns the stored data (alias); op=4'b0111 request -> accepted, no response, counters unchanged.
- Reset asserted 1 cycle after a load fire -> no response ever appears for that tag; after reset, rdy=1, counters=0, and a fresh load returns with its correct tag.
